// File: rtl/wbus_responder_if.sv
// W-bus signal bundle shared by the initiator (CPU fetch unit) and the
// responder. Signal names match the initiator so ports connect one-to-one.
// Optional byte-lane enables W_SEL exist only when WBUS_RESP_SEL_EN is defined.
interface wbus_responder_if;
    logic        W_STB;
    logic        W_WRITE;
    logic [31:0] W_ADDR;
    logic [31:0] W_DATA_O;
    logic [31:0] W_DATA_I;
    logic        W_ACK;
`ifdef WBUS_RESP_SEL_EN
    logic [3:0]  W_SEL;

    modport master (output W_STB, W_WRITE, W_ADDR, W_DATA_O, W_SEL,
                    input  W_DATA_I, W_ACK);
    modport slave  (input  W_STB, W_WRITE, W_ADDR, W_DATA_O, W_SEL,
                    output W_DATA_I, W_ACK);
`else
    modport master (output W_STB, W_WRITE, W_ADDR, W_DATA_O,
                    input  W_DATA_I, W_ACK);
    modport slave  (input  W_STB, W_WRITE, W_ADDR, W_DATA_O,
                    output W_DATA_I, W_ACK);
`endif
endinterface

// File: rtl/wbus_responder.sv
// W-bus responder: decodes the BASE_NIBBLE region, serves single-word reads
// and writes from a 2**DEPTH_LOG2 x 32 register array, and answers each
// accepted request with a one-cycle W_ACK after WAIT_STATES wait cycles.
// Optional feature macro: WBUS_RESP_SEL_EN enables per-byte write lanes (W_SEL).
// The array commits (write) or is read into W_DATA_I on the edge entering ACK;
// W_ACK is registered off the ACK state, so it is seen one edge later together
// with the already-stable read data. All outputs come straight from flops.
module wbus_responder #(
    parameter logic [3:0] BASE_NIBBLE = 4'h8,
    parameter int         DEPTH_LOG2  = 6,
    parameter int         WAIT_STATES = 2
) (
    input  logic              W_CLK,
    input  logic              W_RST_N,
    wbus_responder_if.slave   bus
);
    localparam int         LP_DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] LP_WS    = WAIT_STATES[3:0];

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_HOLD} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_next;
    logic                    r_ack;
    logic [31:0]             r_rdata;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic                    r_write;
    logic [31:0]             r_wdata;
    logic [31:0]             r_mem [0:LP_DEPTH-1];

    logic                    w_hit;
    logic                    w_accept;
    logic                    w_commit;
    logic [DEPTH_LOG2-1:0]   w_req_idx;
    logic                    w_req_write;
    logic [31:0]             w_req_wdata;
    logic [3:0]              w_req_be;
    logic                    w_unused_addr;

    // Word index above DEPTH_LOG2 and the byte offset are deliberately dropped
    // (addresses alias); only the top nibble participates in decode.
    assign w_unused_addr = ^{bus.W_ADDR[27:DEPTH_LOG2+2], bus.W_ADDR[1:0]};

    assign w_hit    = bus.W_STB && (bus.W_ADDR[31:28] == BASE_NIBBLE);
    assign w_accept = (r_state == ST_IDLE) && w_hit;
    // Only IDLE and WAIT can move into ACK, so this marks the commit edge.
    assign w_commit = (w_state_next == ST_ACK);

    // With zero wait states the commit happens on the accept edge itself, so
    // the request fields are taken live from the bus while still in IDLE.
    assign w_req_idx   = (r_state == ST_IDLE) ? bus.W_ADDR[DEPTH_LOG2+1:2] : r_idx;
    assign w_req_write = (r_state == ST_IDLE) ? bus.W_WRITE : r_write;
    assign w_req_wdata = (r_state == ST_IDLE) ? bus.W_DATA_O : r_wdata;

`ifdef WBUS_RESP_SEL_EN
    logic [3:0] r_be;
    assign w_req_be = (r_state == ST_IDLE) ? bus.W_SEL : r_be;

    // Byte-lane enables are captured with the rest of the request.
    always_ff @(posedge W_CLK or negedge W_RST_N) begin
        if (!W_RST_N) begin
            r_be <= 4'h0;
        end else if (w_accept) begin
            r_be <= bus.W_SEL;
        end
    end
`else
    assign w_req_be = 4'hF;
`endif

    // Next-state and wait counter: accept, count down, abort on dropped
    // strobe, single ack, then hold until the initiator releases the strobe.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_hit) begin
                    if (LP_WS == 4'd0) begin
                        w_state_next = ST_ACK;
                    end else begin
                        w_state_next = ST_WAIT;
                        w_cnt_next   = LP_WS - 4'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (!bus.W_STB) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = 4'd0;
                end else if (r_cnt == 4'd0) begin
                    w_state_next = ST_ACK;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ST_ACK:  w_state_next = ST_HOLD;
            ST_HOLD: begin
                if (!bus.W_STB) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State, request capture, ack pulse, read data and array commit. The array
    // lives under the reset branch's else so a held reset can never write it,
    // yet its contents are not cleared by reset.
    always_ff @(posedge W_CLK or negedge W_RST_N) begin
        if (!W_RST_N) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_ack   <= 1'b0;
            r_rdata <= 32'h0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_wdata <= 32'h0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ack   <= (r_state == ST_ACK);
            if (w_accept) begin
                r_idx   <= bus.W_ADDR[DEPTH_LOG2+1:2];
                r_write <= bus.W_WRITE;
                r_wdata <= bus.W_DATA_O;
            end
            if (w_commit) begin
                if (w_req_write) begin
                    for (int i = 0; i < 4; i++) begin
                        if (w_req_be[i]) begin
                            r_mem[w_req_idx][8*i +: 8] <= w_req_wdata[8*i +: 8];
                        end
                    end
                end else begin
                    r_rdata <= r_mem[w_req_idx];
                end
            end
        end
    end

    assign bus.W_ACK    = r_ack;
    assign bus.W_DATA_I = r_rdata;
endmodule

// File: tb/tb_wbus_responder.sv
// Directed bench for wbus_responder: one instance with two wait states and one
// with none. Expected read data goes into a scoreboard queue when a read is
// issued and is popped and compared when the ack arrives.
module tb_wbus_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wbus_responder_if bus_a ();
    wbus_responder_if bus_b ();

    wbus_responder #(.BASE_NIBBLE(4'h8), .DEPTH_LOG2(6), .WAIT_STATES(2)) dut_a (
        .W_CLK(clk), .W_RST_N(rst_n), .bus(bus_a.slave));
    wbus_responder #(.BASE_NIBBLE(4'h8), .DEPTH_LOG2(6), .WAIT_STATES(0)) dut_b (
        .W_CLK(clk), .W_RST_N(rst_n), .bus(bus_b.slave));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [31:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input bit stb, input bit we,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] sel);
        if (which == 0) begin
            bus_a.W_STB = stb; bus_a.W_WRITE = we; bus_a.W_ADDR = addr; bus_a.W_DATA_O = data;
`ifdef WBUS_RESP_SEL_EN
            bus_a.W_SEL = sel;
`endif
        end else begin
            bus_b.W_STB = stb; bus_b.W_WRITE = we; bus_b.W_ADDR = addr; bus_b.W_DATA_O = data;
`ifdef WBUS_RESP_SEL_EN
            bus_b.W_SEL = sel;
`endif
        end
    endtask

    task automatic get(input int which, output logic ack, output logic [31:0] d);
        ack = (which == 0) ? bus_a.W_ACK : bus_b.W_ACK;
        d   = (which == 0) ? bus_a.W_DATA_I : bus_b.W_DATA_I;
    endtask

    // One transfer: accept edge, bounded wait for ack, latency/data checks,
    // optional extra strobe-held cycles, then release and count all acks.
    task automatic xfer(input int which, input bit we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] sel,
                        input int exp_lat, input int hold, input string tag,
                        output int ack_cyc);
        int e0;
        int acks;
        bit got;
        logic ack;
        logic [31:0] d;
        logic [31:0] exp;
        drive(which, 1'b1, we, addr, data, sel);
        @(posedge clk); #1;
        e0 = cyc;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk); #1;
            get(which, ack, d);
            if (ack) got = 1'b1;
        end
        check({tag, " ack_latency"}, got ? (cyc - e0) : -1, exp_lat);
        ack_cyc = cyc;
        if (!we) begin
            exp = exp_q.pop_front();
            if (got) check({tag, " rdata"}, d, exp);
        end
        acks = got ? 1 : 0;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            get(which, ack, d);
            if (ack) acks++;
        end
        drive(which, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1;
        get(which, ack, d);
        if (ack) acks++;
        check({tag, " ack_count"}, acks, 1);
        $display("txn %s dut=%0d we=%0d addr=0x%08h data=0x%08h lat=%0d",
                 tag, which, we, addr, we ? data : d, got ? (cyc - e0 - 1 - hold) : -1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int c1;
        int c2;
        int acks;
        logic ack;
        logic [31:0] d;

        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ack", bus_a.W_ACK, 32'h0);
        check("reset rdata", bus_a.W_DATA_I, 32'h0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic write then read, two wait states: ack 3 edges after accept.
        xfer(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 3, 0, "wr_basic", c);
        exp_q.push_back(32'hDEAD_BEEF);
        xfer(0, 1'b0, 32'h8000_0010, 32'h0, 4'hF, 3, 0, "rd_basic", c);

        // Decode miss: strobe held 20 cycles outside the region.
        drive(0, 1'b1, 1'b1, 32'h1000_0010, 32'h0BAD_0BAD, 4'hF);
        acks = 0;
        repeat (20) begin
            @(posedge clk); #1;
            get(0, ack, d);
            if (ack) acks++;
        end
        check("miss ack_count", acks, 0);
        $display("txn miss dut=0 addr=0x10000010 acks=%0d", acks);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1;
        exp_q.push_back(32'hDEAD_BEEF);
        xfer(0, 1'b0, 32'h8000_0010, 32'h0, 4'hF, 3, 0, "rd_after_miss", c);

        // Address wrap: 0x100 aliases word 0.
        xfer(0, 1'b1, 32'h8000_0100, 32'h1234_5678, 4'hF, 3, 0, "wr_wrap", c);
        exp_q.push_back(32'h1234_5678);
        xfer(0, 1'b0, 32'h8000_0000, 32'h0, 4'hF, 3, 0, "rd_wrap", c);

        // Strobe held 10 cycles past ack gives a single ack.
        xfer(0, 1'b1, 32'h8000_0008, 32'hCAFE_F00D, 4'hF, 3, 10, "wr_hold", c);
        exp_q.push_back(32'hCAFE_F00D);
        xfer(0, 1'b0, 32'h8000_0008, 32'h0, 4'hF, 3, 0, "rd_hold", c);

        // Abort: strobe dropped during WAIT, word keeps its old value.
        xfer(0, 1'b1, 32'h8000_0004, 32'h0102_0304, 4'hF, 3, 0, "wr_pre_abort", c);
        drive(0, 1'b1, 1'b1, 32'h8000_0004, 32'hAAAA_5555, 4'hF);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        acks = 0;
        repeat (6) begin
            @(posedge clk); #1;
            get(0, ack, d);
            if (ack) acks++;
        end
        check("abort ack_count", acks, 0);
        $display("txn abort dut=0 addr=0x80000004 acks=%0d", acks);
        exp_q.push_back(32'h0102_0304);
        xfer(0, 1'b0, 32'h8000_0004, 32'h0, 4'hF, 3, 0, "rd_abort", c);

        // Asynchronous reset mid-WAIT clears outputs before any clock edge.
        drive(0, 1'b1, 1'b1, 32'h8000_0010, 32'h5555_5555, 4'hF);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("async_rst ack", bus_a.W_ACK, 32'h0);
        check("async_rst rdata", bus_a.W_DATA_I, 32'h0);
        $display("txn async_reset dut=0 ack=%0b rdata=0x%08h", bus_a.W_ACK, bus_a.W_DATA_I);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(32'hDEAD_BEEF);
        xfer(0, 1'b0, 32'h8000_0010, 32'h0, 4'hF, 3, 0, "rd_after_rst", c);

        // Zero wait states: ack one edge after accept, reads 3 cycles apart.
        xfer(1, 1'b1, 32'h8000_0020, 32'h0BAD_F00D, 4'hF, 1, 0, "b_wr", c);
        exp_q.push_back(32'h0BAD_F00D);
        xfer(1, 1'b0, 32'h8000_0020, 32'h0, 4'hF, 1, 0, "b_rd1", c1);
        exp_q.push_back(32'h0BAD_F00D);
        xfer(1, 1'b0, 32'h8000_0020, 32'h0, 4'hF, 1, 0, "b_rd2", c2);
        check("b2b spacing", c2 - c1, 3);

`ifdef WBUS_RESP_SEL_EN
        // Byte lanes: only W_SEL lanes change; W_SEL=0 still acks.
        xfer(0, 1'b1, 32'h8000_0030, 32'h1122_3344, 4'hF, 3, 0, "sel_pre", c);
        xfer(0, 1'b1, 32'h8000_0030, 32'hAABB_CCDD, 4'b0101, 3, 0, "sel_wr", c);
        exp_q.push_back(32'h11BB_33DD);
        xfer(0, 1'b0, 32'h8000_0030, 32'h0, 4'h0, 3, 0, "sel_rd", c);
        xfer(0, 1'b1, 32'h8000_0030, 32'hFFFF_FFFF, 4'h0, 3, 0, "sel_none", c);
        exp_q.push_back(32'h11BB_33DD);
        xfer(0, 1'b0, 32'h8000_0030, 32'h0, 4'hF, 3, 0, "sel_rd2", c);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wbus_responder.md
# wbus_responder

Word-addressed W-bus responder: the target end of the W-bus that the CPU fetch unit drives as initiator. It decodes the 0x8xxxxxxx region, serves single-word reads and writes from an internal register array, and answers each accepted request with a one-cycle `W_ACK` after a fixed number of wait states. It sits on the W-bus next to the CPU and shares the initiator's signal names, so ports connect one-to-one.

## Interface
- `BASE_NIBBLE`, 4'h8: value of `W_ADDR[31:28]` that selects this responder.
- `DEPTH_LOG2`, 6: log2 of the word count (64 words × 32 bit).
- `WAIT_STATES`, 2: extra cycles between acceptance and `W_ACK`; legal range 0–15.
- `W_CLK`  in  1  bus clock; all logic on the rising edge.
- `W_RST_N`  in  1  reset, asynchronous, active-low.
- `W_STB`  in  1  request strobe from the initiator; held until `W_ACK` is seen.
- `W_WRITE`  in  1  1 = write, 0 = read; qualified by `W_STB`.
- `W_ADDR`  in  32  byte address; word index = `W_ADDR[DEPTH_LOG2+1:2]`.
- `W_DATA_O`  in  32  write data (initiator output).
- `W_DATA_I`  out  32  read data (initiator input), registered.
- `W_ACK`  out  1  transfer complete, registered, one-cycle pulse.
- `W_SEL`  in  4  byte-lane enables; present only with `WBUS_RESP_SEL_EN`.

## Operation
- States: IDLE, WAIT, ACK, HOLD.
- IDLE: at an edge with `W_STB`=1 and `W_ADDR[31:28]==BASE_NIBBLE`, the request is accepted. Address, `W_WRITE`, `W_DATA_O` (and `W_SEL`) are latched, and later changes on those inputs are ignored. Next state: WAIT with counter = `WAIT_STATES`-1, or ACK when `WAIT_STATES`=0.
- A non-matching `W_STB` is ignored: stay in IDLE, no ack, no state change. Non-responsiveness is the defined miss behaviour.
- WAIT: the counter decrements each edge. When the counter reaches 0, go to ACK. If `W_STB` is sampled 0 in WAIT, abort to IDLE with no write and no ack.
- ACK: `W_ACK`=1 for exactly this cycle.
  - Write: the array word is updated on the edge entering ACK.
  - Read: `W_DATA_I` is loaded with the array word on the edge entering ACK.
  - Always go to HOLD next.
- HOLD: wait for `W_STB`=0, then go to IDLE. A strobe held high does not start a second transfer.
- Address wrap: word index bits above `DEPTH_LOG2` are ignored. Addresses 0x8000_0100 and 0x8000_0000 alias when `DEPTH_LOG2`=6.
- `W_DATA_I` holds the last read value until the next read ack. Writes do not change it.
- Reset (asynchronous, any state, including mid-transfer):
  - state = IDLE, `W_ACK`=0, `W_DATA_I`=0, counter cleared.
  - Array contents are not reset.
  - A transfer in flight is dropped, and no write occurs if reset precedes the ACK edge.

## Timing
- Request sampled high at edge E0: `W_ACK` is high from edge E0+`WAIT_STATES`+1 to E0+`WAIT_STATES`+2.
- `WAIT_STATES`=0 gives `W_ACK` one cycle after acceptance.
- Minimum spacing between accepts: ack cycle + 1 HOLD cycle with `W_STB`=0 + IDLE sample. Back-to-back transfers therefore take `WAIT_STATES`+3 cycles each.
- Read-after-write to the same word returns the new value. The write commits at the earlier ack edge.
- No combinational path from any input to any output.

## Configuration
- `WBUS_RESP_SEL_EN` defined:
  - `W_SEL[3:0]` port exists and is latched at accept.
  - On write, byte lane i (`W_DATA_O[8i+7:8i]`) updates only if `W_SEL[i]`=1.
  - `W_SEL`=0 still acks but changes nothing.
  - Reads ignore `W_SEL` and return the full word.
- `WBUS_RESP_SEL_EN` undefined: no `W_SEL` port, and every write updates all 32 bits.

## Test plan
- Basic write/read, `WAIT_STATES`=2:
  - Write 0xDEADBEEF to 0x8000_0010 → `W_ACK` pulses once, 3 edges after accept.
  - Read of 0x8000_0010 → `W_DATA_I`=0xDEADBEEF during the ack cycle.
- Decode miss: `W_STB`=1 at 0x1000_0010 for 20 cycles → `W_ACK` never asserts, state stays IDLE.
  - A follow-up read of 0x8000_0010 still returns the prior value.
- Wrap and hold:
  - Write 0x12345678 to 0x8000_0100, then read 0x8000_0000 → 0x12345678.
  - Holding `W_STB` high for 10 cycles after ack → exactly one `W_ACK`.
- Abort and reset:
  - Drop `W_STB` in WAIT during a write of 0xAAAA5555 to 0x8000_0004 → no ack, word keeps its old value.
  - Assert `W_RST_N`=0 mid-WAIT → `W_ACK`=0 and `W_DATA_I`=0 immediately, without waiting for a clock edge.
- `WAIT_STATES`=0: ack 1 cycle after accept. Back-to-back reads are spaced 3 cycles apart.
- With `WBUS_RESP_SEL_EN`: preload 0x11223344, write 0xAABBCCDD with `W_SEL`=4'b0101 → read returns 0x11BB33DD.
